// File: rtl/gf163_inverter.sv
// Multiplicative inverse over GF(2^163) by the binary extended Euclidean algorithm,
// one iteration per clock.
module gf163_inverter #(
    parameter int unsigned M = 163,
    parameter logic [M:0]  F = 164'h8_0000_0000_0000_0000_0000_0000_0000_0000_0000_00C9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] a,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [M-1:0] z
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [M-1:0] ONE   = M'(1);
    localparam logic [M:0]   ONE_V = (M + 1)'(1);

    state_t       state;
    logic [M-1:0] u;
    logic [M:0]   v;
    logic [M-1:0] g1;
    logic [M-1:0] g2;

    // Divide by x modulo f: add f first when g is odd so the shift is exact.
    function automatic logic [M-1:0] half_mod(input logic [M-1:0] g);
        logic [M:0] t;
        t = g[0] ? ({1'b0, g} ^ F) : {1'b0, g};
        return t[M:1];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            z     <= '0;
            u     <= '0;
            v     <= '0;
            g1    <= '0;
            g2    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (a == '0) begin
                            // Zero has no inverse: report straight away.
                            state <= FIN;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            z     <= '0;
                        end else begin
                            state <= RUN;
                            u     <= a;
                            v     <= F;
                            g1    <= ONE;
                            g2    <= '0;
                        end
                    end
                end
                RUN: begin
                    if (u == ONE) begin
                        z     <= g1;
                        err   <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else if (v == ONE_V) begin
                        z     <= g2;
                        err   <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else if (!u[0]) begin
                        u  <= u >> 1;
                        g1 <= half_mod(g1);
                    end else if (!v[0]) begin
                        v  <= v >> 1;
                        g2 <= half_mod(g2);
                    end else if ({1'b0, u} > v) begin
                        // v < u < 2^M here, so v's top bit is already clear.
                        u  <= u ^ v[M-1:0];
                        g1 <= g1 ^ g2;
                    end else begin
                        v  <= v ^ {1'b0, u};
                        g2 <= g2 ^ g1;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf163_inverter.sv
// Directed-vector and random-operand bench for gf163_inverter; random results are
// checked by multiplying back with an independent GF(2^163) multiplier model.
module tb_gf163_inverter;

    localparam int unsigned M = 163;
    localparam logic [M:0]  FP = (164'd1 << 163) | 164'hC9;

    localparam logic [M-1:0] XI1 = (M'(1) << 162) | M'(7'h64);
    localparam logic [M-1:0] XI2 = (M'(1) << 161) | M'(7'h32);
    localparam logic [M-1:0] XI3 = (M'(1) << 160) | M'(7'h19);

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [M-1:0] a;
    logic         busy;
    logic         done;
    logic         err;
    logic [M-1:0] z;

    int applied     = 0;
    int miscompares = 0;

    typedef struct {
        logic [M-1:0] a;
        logic [M-1:0] z;
        logic         err;
        int           lat;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    gf163_inverter dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .z     (z)
    );

    task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Shift-and-add field multiplication with reduction after every shift.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
        logic [M:0] r;
        r = '0;
        for (int i = M - 1; i >= 0; i--) begin
            r = r << 1;
            if (r[M]) r = r ^ FP;
            if (y[i]) r[M-1:0] = r[M-1:0] ^ x;
        end
        return r[M-1:0];
    endfunction

    function automatic logic [M-1:0] rnd_nonzero();
        logic [M-1:0] r;
        for (int k = 0; k < M; k++) r[k] = 1'($urandom_range(0, 1));
        if (r == '0) r = M'(1);
        return r;
    endfunction

    // Called and returns at a falling edge; optionally pokes start while busy.
    task automatic do_inv(input logic [M-1:0] av, input bit junk,
                          output logic [M-1:0] zr, output logic er, output int lat,
                          output bit seen, output logic done_after, output logic busy_after);
        a     = av;
        start = 1'b1;
        lat   = 0;
        seen  = 1'b0;
        while (!seen && lat < 700) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            if (done) seen = 1'b1;
            else if (junk && busy && $urandom_range(0, 7) == 0) begin
                start = 1'b1;
                a     = rnd_nonzero();
            end
        end
        zr = z;
        er = err;
        @(negedge clk);
        start      = 1'b0;
        done_after = done;
        busy_after = busy;
    endtask

    initial begin
        logic [M-1:0] zr;
        logic [M-1:0] av;
        logic         er;
        logic         da;
        logic         ba;
        int           lat;
        int           cnt;
        bit           seen;

        vecs[0] = '{M'(1), M'(1), 1'b0, 2};
        vecs[1] = '{M'(0), M'(0), 1'b1, 1};
        vecs[2] = '{M'(1), M'(1), 1'b0, 2};
        vecs[3] = '{M'(2), XI1,   1'b0, -1};
        vecs[4] = '{M'(4), XI2,   1'b0, -1};
        vecs[5] = '{XI1,   M'(2), 1'b0, -1};
        vecs[6] = '{XI2,   M'(4), 1'b0, -1};
        vecs[7] = '{M'(8), XI3,   1'b0, -1};
        vecs[8] = '{XI3,   M'(8), 1'b0, -1};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", M'(busy), M'(0));
        chk("reset_done", M'(done), M'(0));
        chk("reset_err",  M'(err),  M'(0));
        chk("reset_z",    z,        M'(0));
        rst = 1'b0;

        // a=1: busy must cover exactly the RUN and FIN cycles.
        a     = M'(1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt   = 0;
        repeat (6) begin
            if (busy) cnt++;
            @(negedge clk);
        end
        chk("busy_len_a1", M'(cnt), M'(2));

        for (int i = 0; i < 9; i++) begin
            do_inv(vecs[i].a, 1'b0, zr, er, lat, seen, da, ba);
            chk($sformatf("vec%0d_done_seen", i), M'(seen), M'(1));
            chk($sformatf("vec%0d_z", i), zr, vecs[i].z);
            chk($sformatf("vec%0d_err", i), M'(er), M'(vecs[i].err));
            if (vecs[i].lat >= 0) chk($sformatf("vec%0d_latency", i), M'(lat), M'(vecs[i].lat));
            chk($sformatf("vec%0d_done_width", i), M'(da), M'(0));
        end

        // Random operands, back-to-back, with stray start pulses while busy.
        for (int i = 0; i < 100; i++) begin
            av = rnd_nonzero();
            do_inv(av, 1'b1, zr, er, lat, seen, da, ba);
            chk($sformatf("rnd%0d_done_seen", i), M'(seen), M'(1));
            chk($sformatf("rnd%0d_za", i), gf_mul(zr, av), M'(1));
            chk($sformatf("rnd%0d_err", i), M'(er), M'(0));
            chk($sformatf("rnd%0d_done_width", i), M'(da), M'(0));
        end

        // Reset in the middle of a long inversion.
        av      = rnd_nonzero();
        av[162] = 1'b1;
        av[0]   = 1'b1;
        a       = av;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst_pre_busy", M'(busy), M'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", M'(busy), M'(0));
        chk("midrst_done", M'(done), M'(0));
        chk("midrst_z",    z,        M'(0));
        chk("midrst_err",  M'(err),  M'(0));
        repeat (3) @(negedge clk);
        chk("midrst_no_done", M'(done), M'(0));
        do_inv(av, 1'b0, zr, er, lat, seen, da, ba);
        chk("postrst_done_seen", M'(seen), M'(1));
        chk("postrst_za", gf_mul(zr, av), M'(1));
        chk("postrst_err", M'(er), M'(0));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
